// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder sequencer driving an external 4-bit adder slice one nibble per clock.
// Optional signed-overflow output out_ovf is enabled by defining NIBBLE_ADDER_OVF_EN.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef NIBBLE_ADDER_OVF_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, nxt_idx;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [3:0]       add_a_q, add_a_d, add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
`ifdef NIBBLE_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // The slice drive is registered, so each RUN edge preloads the nibble for the following cycle;
  // add_cin_q doubles as the carry register between nibbles.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    add_a_d     = 4'h0;
    add_b_d     = 4'h0;
    add_cin_d   = 1'b0;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
`ifdef NIBBLE_ADDER_OVF_EN
    ovf_d       = ovf_q;
`endif
    nxt_idx     = idx_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = in_a;
          b_d        = in_b;
          add_a_d    = in_a[3:0];
          add_b_d    = in_b[3:0];
          add_cin_d  = in_cin;
          idx_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        sum_d = (sum_q & ~(WIDTH'(4'hF) << {idx_q, 2'b00}))
              | (WIDTH'(add_sum) << {idx_q, 2'b00});
        if (idx_q == LAST_IDX) begin
          cout_d      = add_cout;
`ifdef NIBBLE_ADDER_OVF_EN
          ovf_d       = add_a_q[3] ^ add_b_q[3] ^ add_sum[3] ^ add_cout;
`endif
          idx_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          idx_d     = nxt_idx;
          add_a_d   = 4'(a_q >> {nxt_idx, 2'b00});
          add_b_d   = 4'(b_q >> {nxt_idx, 2'b00});
          add_cin_d = add_cout;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      add_a_q     <= 4'h0;
      add_b_q     <= 4'h0;
      add_cin_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef NIBBLE_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef NIBBLE_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
`ifdef NIBBLE_ADDER_OVF_EN
  assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench: real 4-bit adder on the add_* ports, directed scenarios plus random ops vs. A+B+cin.
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        busy;
`ifdef NIBBLE_ADDER_OVF_EN
  logic        out_ovf;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] seq_a [4];

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
`ifdef NIBBLE_ADDER_OVF_EN
    .out_ovf(out_ovf),
`endif
    .busy(busy)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake one operand set and wait (bounded) for out_valid; lat counts cycles after the handshake.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin, output int lat);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      if (lat <= 4) seq_a[lat-1] = add_a;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got rdy=%b vld=%b busy=%b, expected 1 0 0", in_ready, out_valid, busy);
    end
    vectors++;
    if (out_sum !== 16'h0 || out_cout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_result: got %h/%b, expected 0000/0", out_sum, out_cout);
    end
    vectors++;
    if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_add: got %h %h %b, expected 0 0 0", add_a, add_b, add_cin);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset: got rdy=%b busy=%b, expected 1 0", in_ready, busy);
    end
  endtask

  task automatic test_carry_chain();
    int lat;
    run_op(16'hFFFF, 16'h0001, 1'b0, lat);
    vectors++;
    if (lat !== 5) begin
      miscompares++;
      $display("[TB] FAIL latency: got %0d, expected 5", lat);
    end
    vectors++;
    if (out_sum !== 16'h0000 || out_cout !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL carry_chain: got %h/%b, expected 0000/1", out_sum, out_cout);
    end
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL done_flags: got rdy=%b busy=%b, expected 0 1", in_ready, busy);
    end
    tick();
  endtask

  task automatic test_nibble_order();
    int lat;
    logic [3:0] exp_seq [4];
    exp_seq = '{4'h4, 4'h3, 4'h2, 4'h1};
    run_op(16'h1234, 16'h4321, 1'b1, lat);
    vectors++;
    if (out_sum !== 16'h5556 || out_cout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL nibble_sum: got %h/%b, expected 5556/0", out_sum, out_cout);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (seq_a[i] !== exp_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL add_a_seq[%0d]: got %h, expected %h", i, seq_a[i], exp_seq[i]);
      end
    end
    tick();
  endtask

  task automatic test_stall();
    int lat;
    logic [15:0] a, b, exp_sum;
    logic cin, exp_cout;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    {exp_cout, exp_sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    out_ready = 1'b0;
    run_op(a, b, cin, lat);
    in_a = 16'hAAAA; in_b = 16'h5555; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      vectors++;
      if (out_valid !== 1'b1 || out_sum !== exp_sum || out_cout !== exp_cout || in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall[%0d]: got vld=%b %h/%b rdy=%b, expected 1 %h/%b 0",
                 i, out_valid, out_sum, out_cout, in_ready, exp_sum, exp_cout);
      end
      if (i < 2) tick();
    end
    tick();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_release: got rdy=%b vld=%b busy=%b, expected 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    in_a = 16'h9999; in_b = 16'h7777; in_cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_ctrl: got rdy=%b vld=%b busy=%b, expected 1 0 0", in_ready, out_valid, busy);
    end
    vectors++;
    if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_add: got %h %h %b, expected 0 0 0", add_a, add_b, add_cin);
    end
    run_op(16'h0F0F, 16'h00F1, 1'b0, lat);
    vectors++;
    if (out_sum !== 16'h1000 || out_cout !== 1'b0 || lat !== 5) begin
      miscompares++;
      $display("[TB] FAIL after_abort: got %h/%b lat=%0d, expected 1000/0 lat=5", out_sum, out_cout, lat);
    end
    tick();
  endtask

  task automatic test_ignore_busy();
    int lat;
    in_a = 16'h1357; in_b = 16'h2468; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    in_a = 16'hAAAA; in_b = 16'hAAAA; in_cin = 1'b1; in_valid = 1'b1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL run_in_ready: got %b, expected 0", in_ready);
    end
    tick();
    in_valid = 1'b0;
    lat = 3;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    vectors++;
    if (out_sum !== 16'h37BF || out_cout !== 1'b0 || lat !== 5) begin
      miscompares++;
      $display("[TB] FAIL ignore_busy: got %h/%b lat=%0d, expected 37bf/0 lat=5", out_sum, out_cout, lat);
    end
    tick();
  endtask

`ifdef NIBBLE_ADDER_OVF_EN
  task automatic test_overflow();
    int lat;
    run_op(16'h7FFF, 16'h0001, 1'b0, lat);
    vectors++;
    if (out_ovf !== 1'b1 || out_sum !== 16'h8000) begin
      miscompares++;
      $display("[TB] FAIL ovf_pos: got ovf=%b %h, expected 1 8000", out_ovf, out_sum);
    end
    tick();
    run_op(16'hFFFF, 16'h0001, 1'b0, lat);
    vectors++;
    if (out_ovf !== 1'b0 || out_cout !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovf_neg: got ovf=%b cout=%b, expected 0 1", out_ovf, out_cout);
    end
    tick();
  endtask
`endif

  // Back-to-back random ops: each new handshake lands on the first IDLE cycle.
  task automatic test_random();
    int lat;
    logic [15:0] a, b, exp_sum;
    logic cin, exp_cout, exp_ovf;
    for (int n = 0; n < 1000; n++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      if (n % 50 == 0) a = 16'hFFFF;
      {exp_cout, exp_sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};
      exp_ovf = (a[15] == b[15]) && (exp_sum[15] != a[15]);
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL rand_ready[%0d]: got %b, expected 1", n, in_ready);
      end
      run_op(a, b, cin, lat);
      vectors++;
      if (out_sum !== exp_sum || out_cout !== exp_cout || lat !== 5) begin
        miscompares++;
        $display("[TB] FAIL rand[%0d] %h+%h+%b: got %h/%b lat=%0d, expected %h/%b lat=5",
                 n, a, b, cin, out_sum, out_cout, lat, exp_sum, exp_cout);
      end
`ifdef NIBBLE_ADDER_OVF_EN
      vectors++;
      if (out_ovf !== exp_ovf) begin
        miscompares++;
        $display("[TB] FAIL rand_ovf[%0d]: got %b, expected %b", n, out_ovf, exp_ovf);
      end
`else
      if (exp_ovf === 1'bx) $display("[TB] unexpected x in overflow model");
`endif
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_nibble_order();
    test_stall();
    test_reset_mid_run();
    test_ignore_busy();
`ifdef NIBBLE_ADDER_OVF_EN
    test_overflow();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
